framebuffer_reader: RTL and testbench
=====================================

# framebuffer_reader

Read side of the camera framebuffer: fetches one frame of 12-bit pixels from the dual-port BRAM in raster order and emits them as a valid/ready pixel stream toward the display/processing pipeline. Compensates for the BRAM read latency with a small credit-controlled output FIFO, so downstream backpressure never drops or duplicates a pixel. Marks frame start and line end on the stream and pulses `frame_done` when the last pixel has been accepted.

## Interface
- `FRAME_WIDTH`, 240, pixels per line.
- `FRAME_HEIGHT`, 320, lines per frame.
- `BRAM_LATENCY`, 2, BRAM read latency in cycles (1..3 supported).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin one frame; sampled only in IDLE.
- `bram_addr`  out  17  BRAM read address.
- `bram_data_out`  in  12  BRAM read data, valid `BRAM_LATENCY` cycles after address.
- `axiov`  out  1  output pixel valid.
- `axiod`  out  12  output pixel.
- `axior`  in  1  downstream ready.
- `axiou`  out  1  first pixel of frame (x=0,y=0); qualified by `axiov`.
- `axiol`  out  1  last pixel of line (x=FRAME_WIDTH-1); qualified by `axiov`.
- `busy`  out  1  high from accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after final pixel handshake.

## Operation
- States: IDLE, FETCH, DRAIN.
  - IDLE: `start`=1 -> FETCH; clear col/row counters, addr=0.
  - FETCH: issue one read per cycle when credit available; after issuing address FRAME_WIDTH*FRAME_HEIGHT-1 -> DRAIN.
  - DRAIN: wait until FIFO empty and no reads in flight and last pixel handshaked -> IDLE, pulse `frame_done`.
- Handshake: pixel transfers when `axiov && axior`. `axiod/axiou/axiol` held stable while `axiov && !axior`. `axiov` never deasserts without a transfer.
- FIFO: depth `BRAM_LATENCY+2`, entries {pixel, sof, eol}. Issue permitted only when occupancy + in-flight reads < depth (credit); FIFO never overflows.
- Address: `bram_addr = row*FRAME_WIDTH + col` as an incrementing 17-bit counter (no multiplier); col wraps at FRAME_WIDTH-1 incrementing row. Tags sof/eol computed at issue and delayed by a `BRAM_LATENCY`-deep shift register alongside a read-valid bit.
- `start` while busy ignored.
- Reset (any time, incl. mid-frame): state IDLE, FIFO and in-flight pipeline flushed, all outputs 0 (`bram_addr`=0, `axiov`=0, `axiod`=0, `axiou`=0, `axiol`=0, `busy`=0, `frame_done`=0). In-flight BRAM data after reset discarded.

## Timing
- `start` sampled at edge N -> first address driven after edge N+1 (`busy`=1 after edge N).
- Data captured into FIFO at edge N+1+BRAM_LATENCY; `axiov` first high after edge N+2+BRAM_LATENCY.
- With `axior` held high: one pixel per cycle sustained, no bubbles; frame occupies FRAME_WIDTH*FRAME_HEIGHT consecutive cycles.
- `frame_done` high for exactly the cycle after the final handshake; `busy` falls the same edge.
- Back-to-back frames: `start` accepted in the cycle `frame_done` is high is ignored (state still DRAIN->IDLE); earliest next accept is the following cycle.
- Stall release: pixel stalled under `axior`=0 transfers on the first cycle `axior`=1, next pixel valid the following cycle if FIFO non-empty.

## Configuration
- `FB_READER_MIRROR_EN` defined: horizontal mirror; address within each line descends, `bram_addr = row*FRAME_WIDTH + (FRAME_WIDTH-1-col)`; `axiou`/`axiol` still mark first/last emitted pixel of frame/line.
- Undefined: plain raster order as above. Handshake and timing identical in both builds.

## Test plan
- Reset then `start` with `axior`=1, BRAM preloaded `mem[a]=a[11:0]`: 76800 pixels in order 0,1,2..., `axiou` only on first, `axiol` on every 240th, `axiov` first high at cycle start+4, `frame_done` once.
- Random `axior` (50% duty): stream content identical to above, no drops/duplicates, payload stable during stalls, FIFO occupancy never exceeds 4.
- `axior`=0 for 100 cycles mid-line: `bram_addr` stops advancing after 4 outstanding; resume yields pixel sequence contiguous.
- `start` pulsed during busy: ignored; exactly one frame emitted, `frame_done` one pulse.
- `rst` asserted mid-frame (pixel 5000): outputs 0 immediately; new `start` begins at address 0 with `axiou`=1 on first pixel.
- `FB_READER_MIRROR_EN` build: first line emits 239,238..0 with `axiol` on value 0; line 1 begins 479.

Source files
------------

// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Fetches one frame of 12-bit pixels from a dual-port BRAM in raster order and
//   emits them as a valid/ready stream. A credit-limited FIFO absorbs the BRAM
//   read latency so downstream backpressure never drops or duplicates a pixel.
//
//   Build option: define FB_READER_MIRROR_EN for horizontal mirroring (addresses
//   descend within each line). Handshake and timing are identical in both builds.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           begin one frame (sampled only when idle)
//   bram_addr       BRAM read address
//   bram_data_out   BRAM read data, BRAM_LATENCY cycles after the address
//   axiov/axiod     output pixel valid / pixel
//   axior           downstream ready
//   axiou           first pixel of frame, axiol last pixel of line
//   busy            high from accepted start until frame_done
//   frame_done      one-cycle pulse after the final pixel handshake
`timescale 1ns/1ps
module framebuffer_reader #(
   parameter int unsigned FRAME_WIDTH  = 240,
   parameter int unsigned FRAME_HEIGHT = 320,
   parameter int unsigned BRAM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [16:0] bram_addr,
   input  logic [11:0] bram_data_out,
   output logic        axiov,
   output logic [11:0] axiod,
   input  logic        axior,
   output logic        axiou,
   output logic        axiol,
   output logic        busy,
   output logic        frame_done
);
   localparam int unsigned Depth = BRAM_LATENCY + 2;
   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned CntW  = $clog2(Depth + 1);
   localparam int unsigned CrW   = CntW + 2;
   localparam int unsigned ColW  = $clog2(FRAME_WIDTH);
   localparam int unsigned RowW  = $clog2(FRAME_HEIGHT);
`ifdef FB_READER_MIRROR_EN
   localparam logic [16:0] FirstAddr = 17'(FRAME_WIDTH - 1);
`else
   localparam logic [16:0] FirstAddr = '0;
`endif

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e          state_q, state_d;
   logic [ColW-1:0] col_q;
   logic [RowW-1:0] row_q;
   logic [16:0]     addr_q, addr_d;
   logic            frame_done_q, frame_done_d;

   // Read-valid bit and {sof, eol} tags travel alongside the BRAM pipeline
   logic [BRAM_LATENCY-1:0] vld_q;
   logic [1:0]              tag_q [BRAM_LATENCY];

   logic [13:0]     fifo_mem [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] fifo_cnt_q;

   // Output register acts as the FIFO head and holds payload during stalls
   logic        out_valid_q;
   logic [11:0] out_pix_q;
   logic        out_sof_q, out_eol_q;

   logic           accept, issue, col_last, pos_last, fifo_wr, fifo_rd, xfer;
   logic [CrW-1:0] credit_used;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign col_last = (col_q == ColW'(FRAME_WIDTH - 1));
   assign pos_last = col_last && (row_q == RowW'(FRAME_HEIGHT - 1));
   assign accept   = (state_q == StIdle) && start && !frame_done_q;
   assign xfer     = out_valid_q && axior;
   assign fifo_wr  = vld_q[BRAM_LATENCY-1];
   assign fifo_rd  = (fifo_cnt_q != '0) && (!out_valid_q || axior);

   // Credit counts everything not yet handed downstream; a pixel leaving this
   // cycle frees its slot immediately so the stream sustains one per cycle.
   always_comb begin
      credit_used = CrW'(fifo_cnt_q) + CrW'(out_valid_q && !axior);
      for (int i = 0; i < BRAM_LATENCY; i++) begin
         credit_used = credit_used + CrW'(vld_q[i]);
      end
   end

   assign issue = (state_q == StFetch) && (credit_used < CrW'(Depth));

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      unique case (state_q)
         StIdle:  if (accept) state_d = StFetch;
         StFetch: if (issue && pos_last) state_d = StDrain;
         StDrain: begin
            if ((fifo_cnt_q == '0) && (vld_q == '0) && xfer) begin
               state_d      = StIdle;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      if (accept) begin
         addr_d = FirstAddr;
      end else if (issue) begin
         if (pos_last) begin
            addr_d = '0;
         end else begin
`ifdef FB_READER_MIRROR_EN
            // Jump from the start of this line to the end of the next one
            addr_d = col_last ? addr_q + 17'(2 * FRAME_WIDTH - 1) : addr_q - 17'd1;
`else
            addr_d = addr_q + 17'd1;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         frame_done_q <= 1'b0;
         addr_q       <= '0;
         col_q        <= '0;
         row_q        <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_done_d;
         addr_q       <= addr_d;
         if (accept) begin
            col_q <= '0;
            row_q <= '0;
         end else if (issue) begin
            col_q <= col_last ? '0 : col_q + ColW'(1);
            if (col_last) row_q <= row_q + RowW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < BRAM_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         vld_q[0] <= issue;
         tag_q[0] <= {(col_q == '0) && (row_q == '0), col_last};
         for (int i = 1; i < BRAM_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr_q] <= {bram_data_out, tag_q[BRAM_LATENCY-1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + CntW'(fifo_wr) - CntW'(fifo_rd);
         if (fifo_rd) begin
            out_valid_q <= 1'b1;
            {out_pix_q, out_sof_q, out_eol_q} <= fifo_mem[rd_ptr_q];
         end else if (xfer) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bram_addr  = addr_q;
   assign axiov      = out_valid_q;
   assign axiod      = out_pix_q;
   assign axiou      = out_sof_q;
   assign axiol      = out_eol_q;
   assign busy       = (state_q != StIdle);
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
`timescale 1ns/1ps
module tb_framebuffer_reader;
   localparam int unsigned W     = 12;
   localparam int unsigned H     = 6;
   localparam int unsigned L     = 2;
   localparam int unsigned NPIX  = W * H;
   localparam int unsigned DEPTH = L + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        axior = 1'b0;
   logic [16:0] bram_addr;
   logic [11:0] bram_data_out;
   logic [11:0] axiod;
   logic        axiov, axiou, axiol, busy, frame_done;

   int tests = 0;
   int fails = 0;
   int mode = 0;       // 0: ready high, 1: random ready, 2: ready low
   int acc = 0;        // pixels accepted in the current frame
   int done_cnt = 0;
   logic [11:0] bram_pipe [L];

   always #5 clk = ~clk;

   framebuffer_reader #(
      .FRAME_WIDTH (W),
      .FRAME_HEIGHT(H),
      .BRAM_LATENCY(L)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bram_addr    (bram_addr),
      .bram_data_out(bram_data_out),
      .axiov        (axiov),
      .axiod        (axiod),
      .axior        (axior),
      .axiou        (axiou),
      .axiol        (axiol),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   // BRAM with mem[a] = a[11:0] and L cycles of read latency
   always @(posedge clk) begin
      bram_pipe[0] <= (32'(bram_addr) < NPIX) ? bram_addr[11:0] : 12'h000;
      for (int i = 1; i < L; i++) bram_pipe[i] <= bram_pipe[i-1];
   end
   assign bram_data_out = bram_pipe[L-1];

   // Reference: BRAM address of the k-th emitted pixel of a frame
   function automatic int unsigned pix_addr(input int unsigned k);
      int unsigned r = k / W;
      int unsigned c = k % W;
`ifdef FB_READER_MIRROR_EN
      return r * W + (W - 1 - c);
`else
      return r * W + c;
`endif
   endfunction

   // Reference: emission index of the pixel stored at address a
   function automatic int unsigned idx_of_addr(input int unsigned a);
`ifdef FB_READER_MIRROR_EN
      return (a / W) * W + (W - 1 - (a % W));
`else
      return a;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: axior = 1'b1;
            1: axior = 1'($urandom_range(0, 1));
            default: axior = 1'b0;
         endcase
      end
   end

   // Compare process: stream content, stall stability and frame_done timing
   initial begin
      logic        busy_prev = 1'b0;
      logic        stall_prev = 1'b0;
      logic        done_due = 1'b0;
      logic [13:0] held = '0;
      int unsigned exp_a;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = 0;
            stall_prev = 1'b0;
            done_due = 1'b0;
         end else begin
            if (!busy_prev && busy) acc = 0;
            if (frame_done) done_cnt++;
            check("frame_done", {31'd0, frame_done}, {31'd0, done_due});
            if (done_due) check("busy_at_done", {31'd0, busy}, 32'd0);
            done_due = 1'b0;
            if (stall_prev) begin
               check("hold_valid", {31'd0, axiov}, 32'd1);
               check("hold_payload", {18'd0, axiod, axiou, axiol}, {18'd0, held});
            end
            if (axiov && axior) begin
               if (acc < NPIX) begin
                  exp_a = pix_addr(acc);
                  check("pixel", {20'd0, axiod}, {20'd0, exp_a[11:0]});
                  check("sof", {31'd0, axiou}, {31'd0, acc == 0});
                  check("eol", {31'd0, axiol}, {31'd0, (acc % W) == W - 1});
               end else begin
                  check("extra_pixel", acc, NPIX - 1);
               end
               acc++;
               if (acc == NPIX) done_due = 1'b1;
            end
            stall_prev = axiov && !axior;
            held = {axiod, axiou, axiol};
         end
         busy_prev = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_addr"}, {15'd0, bram_addr}, 32'd0);
      check({tag, "_axiov"}, {31'd0, axiov}, 32'd0);
      check({tag, "_axiod"}, {20'd0, axiod}, 32'd0);
      check({tag, "_axiou"}, {31'd0, axiou}, 32'd0);
      check({tag, "_axiol"}, {31'd0, axiol}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
   endtask

   // Pulses start for one edge; returns edges from the start edge to first axiov
   task automatic start_frame(output int lat);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("first_addr", {15'd0, bram_addr}, pix_addr(0));
      lat = 0;
      while (lat < 20) begin
         if (axiov) break;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic wait_done(output int cyc, input bit poke);
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (frame_done) break;
         if (poke) start = ($urandom_range(0, 7) == 0);
      end
      start = 1'b0;
      check("frame_timeout", {31'd0, frame_done}, 32'd1);
   endtask

   task automatic wait_acc(input int n);
      int guard = 0;
      while (acc < n && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("wait_acc_timeout", {31'd0, acc >= n}, 32'd1);
   endtask

   initial begin
      int lat, cyc, outstanding;
      logic [16:0] a0;

`ifdef FB_READER_MIRROR_EN
      check("model_pin_first", pix_addr(0), 11);
      check("model_pin_eol", pix_addr(W - 1), 0);
      check("model_pin_line1", pix_addr(W), 23);
`else
      check("model_pin_first", pix_addr(0), 0);
      check("model_pin_eol", pix_addr(W - 1), 11);
      check("model_pin_line1", pix_addr(W), 12);
`endif

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      rst = 1'b0;

      // Frame 1: ready held high, latency and sustained throughput
      mode = 0;
      start_frame(lat);
      check("latency", lat, 2 + L);
      wait_done(cyc, 1'b0);
      check("sustained_cycles", cyc, NPIX);

      // start during the frame_done cycle is ignored, next cycle accepted
      start = 1'b1;
      @(posedge clk);
      #1 check("start_in_done_ignored", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      check("start_next_cycle", {31'd0, busy}, 32'd1);

      // Frame 2: random ready with start pokes while busy
      mode = 1;
      wait_done(cyc, 1'b1);
      repeat (10) @(posedge clk);
      #1 check("idle_after_frame2", {31'd0, busy}, 32'd0);
      check("done_count_2", done_cnt, 2);

      // Frame 3: long stall mid-line, issue must stop at the credit limit
      mode = 0;
      start_frame(lat);
      check("latency_f3", lat, 2 + L);
      wait_acc(W + 5);
      mode = 2;
      repeat (10) @(posedge clk);
      #1 a0 = bram_addr;
      repeat (90) @(posedge clk);
      #1 check("addr_frozen", {15'd0, bram_addr}, {15'd0, a0});
      outstanding = int'(idx_of_addr(32'(bram_addr))) - acc;
      check("outstanding", outstanding, DEPTH);
      check("stall_valid", {31'd0, axiov}, 32'd1);
      mode = 1;
      wait_done(cyc, 1'b0);

      // Frame 4: reset mid-frame, then a fresh frame from address 0
      mode = 0;
      start_frame(lat);
      wait_acc(30);
      rst = 1'b1;
      #1 check_outputs_zero("midrst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mode = 1;
      start_frame(lat);
      check("latency_after_rst", lat, 2 + L);
      wait_done(cyc, 1'b0);
      repeat (5) @(posedge clk);
      #1 check("done_count_final", done_cnt, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
